dsec_ctrl: RTL

DSEC_CTRL -- requirements
Module: dsec_ctrl

---
 rtl/dsec_ctrl.sv | 136 +++++++++++++
 1 files changed

// File: rtl/dsec_ctrl.sv
// dsec_ctrl: sequencing FSM for the encrypt/compress/shift-concat datapath.
// Latency: outputs from the FSM are registered one edge after the deciding inputs are sampled.
// Backpressure: a word is held in HOLD until out_rcvd is seen. Without an ack, a timeout moves the FSM to ERR.
//
// Ports:
//   clk, rst                        clock; asynchronous active-low reset
//   key_config, in_valid, comp_rdy  input side: key setup, data valid, compressor ready
//   scon_done, valid_bits           datapath status: word complete, bits left in compressor
//   flush_req, out_rcvd, err_clr    end-of-stream, downstream ack, error clear
//   stall, rdy, valid_to_comp       combinational datapath controls
//   out_valid, dump_comp, error     registered status
//   error_code, word_cnt            registered sticky error flags and count of delivered words
module dsec_ctrl #(
  parameter int VB_W    = 7,
  parameter int ERR_W   = 64,
  parameter int CNT_W   = 16,
  parameter int TIMEOUT = 256
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             key_config,
  input  logic             in_valid,
  input  logic             out_rcvd,
  input  logic             flush_req,
  input  logic             comp_rdy,
  input  logic             scon_done,
  input  logic [VB_W-1:0]  valid_bits,
  input  logic             err_clr,
  output logic             stall,
  output logic             rdy,
  output logic             valid_to_comp,
  output logic             out_valid,
  output logic             dump_comp,
  output logic             error,
  output logic [ERR_W-1:0] error_code,
  output logic [CNT_W-1:0] word_cnt
);

  typedef enum logic [2:0] {
    S_IDLE, S_KEYCFG, S_RUN, S_HOLD, S_FLUSH, S_ERR
  } state_t;

  localparam int TMO_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  state_t           state, state_nxt;
  logic [3:0]       err_flags;
  logic [3:0]       err_set;
  logic [TMO_W-1:0] tmo_cnt;
  logic             flush_pend;
  logic             word_done;

  always_comb begin
    state_nxt = state;
    err_set   = 4'b0000;
    case (state)
      S_IDLE: begin
        if (key_config)      state_nxt = S_KEYCFG;
        else if (flush_req)  state_nxt = S_FLUSH;
        else if (in_valid)   state_nxt = S_RUN;
      end
      S_KEYCFG: begin
        if (!key_config)     state_nxt = S_IDLE;
      end
      S_RUN: begin
        if (in_valid && !comp_rdy) begin
          state_nxt  = S_ERR;
          err_set[0] = 1'b1;
        end else if (scon_done) state_nxt = S_HOLD;
        else if (flush_req)     state_nxt = S_FLUSH;
        else if (key_config)    state_nxt = S_KEYCFG;
      end
      S_HOLD: begin
        // Key reconfiguration while a word is held corrupts it. This check takes priority over the ack.
        if (key_config) begin
          state_nxt  = S_ERR;
          err_set[2] = 1'b1;
        end else if (out_rcvd) begin
          state_nxt = (flush_pend || flush_req) ? S_FLUSH : S_RUN;
        end else if (TIMEOUT != 0 && tmo_cnt == TMO_LAST) begin
          state_nxt  = S_ERR;
          err_set[1] = 1'b1;
        end
      end
      S_FLUSH: begin
        if (scon_done)                state_nxt = S_HOLD;
        else if (valid_bits == '0)    state_nxt = S_IDLE;
      end
      S_ERR: begin
        if (err_clr)         state_nxt = S_IDLE;
      end
      default:               state_nxt = S_IDLE;
    endcase
    // An ack with nothing held is flagged. In ERR, every input except err_clr is ignored.
    if (out_rcvd && state != S_HOLD && state != S_ERR) err_set[3] = 1'b1;
  end

  assign word_done = (state == S_HOLD) && out_rcvd && !key_config;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= S_IDLE;
      out_valid  <= 1'b0;
      dump_comp  <= 1'b0;
      error      <= 1'b0;
      err_flags  <= 4'b0000;
      word_cnt   <= '0;
      tmo_cnt    <= '0;
      flush_pend <= 1'b0;
    end else begin
      state     <= state_nxt;
      out_valid <= (state_nxt == S_HOLD);
      dump_comp <= (state_nxt == S_FLUSH) && (valid_bits != '0);
      error     <= (state_nxt == S_ERR);
      if (state == S_ERR && err_clr) err_flags <= 4'b0000;
      else                           err_flags <= err_flags | err_set;
      if (word_done) word_cnt <= word_cnt + 1'b1;
      // The counter runs only while HOLD persists, so every entry into HOLD starts it at zero.
      tmo_cnt <= (state == S_HOLD && state_nxt == S_HOLD) ? tmo_cnt + 1'b1 : '0;
      // The flush remains pending while in HOLD. It is armed either by a flush_req
      // received in HOLD or by a word completed during FLUSH.
      flush_pend <= (state_nxt == S_HOLD) &&
                    (flush_pend || state == S_FLUSH || (state == S_HOLD && flush_req));
    end
  end

  always_comb begin
    error_code      = '0;
    error_code[3:0] = err_flags;
  end

  assign stall         = !(state == S_RUN && in_valid && !key_config);
  assign rdy           = comp_rdy && (state == S_IDLE || state == S_RUN);
  assign valid_to_comp = (state == S_RUN) && in_valid && comp_rdy && !key_config;

endmodule
